act_skew_feeder: RTL
====================

# act_skew_feeder

Upstream feeder for the weight-stationary MAC array. It accepts whole activation vectors (one element per array row) over a valid/ready handshake and buffers them in a small FIFO. It drives the array's left edge with diagonally skewed data, so lane k lags lane 0 by k array advances. It also generates the shared `acc_en`, stalls the array cleanly when starved, and flushes with zeros after the last vector of a matrix.

## Interface
- `DATA_WIDTH`, 16, element width; matches the MAC data width
- `N`, 4, array dimension (lanes), ≥1
- `DEPTH`, 4, input FIFO entries, power of two, ≥2

Ports:
- `clk` in 1: single clock, rising edge
- `rstn` in 1: asynchronous, active-low reset
- `in_valid` in 1: input vector valid
- `in_ready` out 1: FIFO can accept
- `in_data` in N*DATA_WIDTH: lane k = bits [k*DATA_WIDTH +: DATA_WIDTH], signed
- `in_last` in 1: vector is the last row of the matrix
- `data_o` out N*DATA_WIDTH: lane k drives row k `data_i` of column 0
- `acc_en_o` out 1: array advance enable, broadcast to all MACs
- `busy_o` out 1: state ≠ IDLE
- `done_o` out 1: one-cycle pulse when the flush completes

## Operation
- FIFO stores {in_last, in_data}. Push on `in_valid && in_ready`. `in_ready = (count < DEPTH)`, registered count; no pop-dependent bypass. Push and pop in the same cycle are legal whenever not full.
- `adv` (combinational) = (state ∈ {IDLE, STREAM} && fifo non-empty) || state == FLUSH. Pop when `adv && state != FLUSH`.
- Skew line: lane k is a (k+1)-deep register chain whose head is fed by the popped lane k, or by 0 in FLUSH. All chains shift only on `adv`; when `adv`=0 they hold.
- `acc_en_o` <= `adv` (registered), so it aligns with the `data_o` update it enables.
- FSM states:
  - IDLE: pop if non-empty → STREAM; if the popped entry has last=1 → FLUSH (or straight to DONE behaviour when N=1).
  - STREAM: pop if non-empty; if empty, stall (`adv`=0). Popped last=1 → FLUSH.
  - FLUSH: N-1 zero advances tracked by a flush counter, with no pops. After the final flush advance → IDLE, and `done_o`=1 in the following cycle. If N=1, a last pop goes to IDLE directly, with `done_o` on the next cycle.
- Pushes continue during FLUSH. The next matrix starts only after return to IDLE.
- Data passes unmodified; no arithmetic, signedness preserved.

## Timing
- Reset values: `data_o`=0, `acc_en_o`=0, `busy_o`=0, `done_o`=0, `in_ready`=1, FIFO empty, state IDLE, flush counter 0.
- Reset mid-operation clears the FIFO, skew chains and FSM immediately. Partially fed data is discarded.
- Latency: vector accepted at edge E0 → earliest pop at E1 → lane 0 valid on `data_o`, with `acc_en_o`=1, in the cycle after E1. Lane k shows the same vector after k further advances (k cycles if unstalled).
- Matrix of R vectors, unstalled, with FIFO prefilled: `acc_en_o` high for exactly R+N-1 consecutive cycles, then `done_o` pulses one cycle after `acc_en_o` falls.
- A starved FIFO mid-matrix drops `acc_en_o` for exactly the empty cycles. The skew is preserved across the stall.
- Full FIFO: `in_ready`=0 until a pop lowers count (visible the cycle after the pop).

## Structure
- Shared package `sa_pkg`: `feed_state_e` enum {IDLE, STREAM, FLUSH}, default `DATA_WIDTH`/`N` constants used across the array.
- Sub-module `sync_fifo` (parameterised width/depth, count output, async active-low reset), reused elsewhere in the array.
- Skew chains as a generate loop over lanes inside `act_skew_feeder`.

## Test plan
- Reset: hold `rstn`=0 mid-stream with `data_o` non-zero → all outputs at reset values, `in_ready`=1, FIFO empty.
- N=4, push rows [1,2,3,4],[5,6,7,8] (last on the second) back-to-back → `acc_en_o` high 5 cycles; lane 0 sees 1,5,0,0,0; lane 3 sees 0,0,0,4,8; `done_o` pulses once after.
- Starvation: push row 1, wait 3 cycles, push row 2 (last) → `acc_en_o` 1,0,0,0,1,…; per-lane sequences are identical to the unstalled case when counted over advances only.
- Backpressure: DEPTH=4, push 6 vectors while the FIFO cannot pop (vectors queued during FLUSH) → `in_ready` drops after 4; no vector is lost or duplicated.
- Back-to-back matrices: a second matrix pushed during FLUSH → its first pop follows the IDLE return; its lane 0 data is never mixed with flush zeros.
- N=1: single vector [7] with last → `acc_en_o` 1 cycle, `data_o`=7, `done_o` next cycle.

Source files
------------

// File: rtl/sa_pkg.sv
// Shared definitions for the weight-stationary MAC array and its edge feeders.
package sa_pkg;

  localparam int SA_DATA_WIDTH = 16;
  localparam int SA_N          = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    FLUSH  = 2'd2
  } feed_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with a show-ahead read port and an occupancy count.
// DEPTH must be a power of two so the pointers wrap naturally.
module sync_fifo #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 4,
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rd_data_o,
  output logic [CW-1:0]    count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [CW-1:0]    count_q;

  // NOTE: the storage array has no reset; the pointers and count alone decide
  // which entries are valid, so clearing them empties the FIFO.
  always_ff @(posedge clk) begin
    if (push_i) begin
      mem_q[wr_ptr_q] <= wr_data_i;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its inputs from before the edge, regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
      end
      if (pop_i) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      case ({push_i, pop_i})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  assign rd_data_o = mem_q[rd_ptr_q];
  assign count_o   = count_q;

endmodule

// File: rtl/act_skew_feeder.sv
// Left-edge activation feeder: buffers whole vectors, skews lane k by k array
// advances, drives the shared acc_en and zero-flushes after the last vector.
module act_skew_feeder
  import sa_pkg::*;
#(
  parameter int DATA_WIDTH = SA_DATA_WIDTH,
  parameter int N          = SA_N,
  parameter int DEPTH      = 4
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [N*DATA_WIDTH-1:0] in_data,
  input  logic                    in_last,
  output logic [N*DATA_WIDTH-1:0] data_o,
  output logic                    acc_en_o,
  output logic                    busy_o,
  output logic                    done_o
);

  localparam int CW  = $clog2(DEPTH + 1);
  localparam int FCW = (N > 2) ? $clog2(N - 1) : 1;
  localparam logic [FCW-1:0] FLUSH_LAST = FCW'((N > 1) ? N - 2 : 0);

  logic [CW-1:0]         fifo_count;
  logic [N*DATA_WIDTH:0] fifo_rd;
  logic                  fifo_empty;
  logic                  push;
  logic                  pop;
  logic                  adv;
  logic                  pop_last;

  feed_state_e    state_q, state_d;
  logic [FCW-1:0] flush_cnt_q, flush_cnt_d;
  logic           done_pend_q, done_pend_d;
  logic           acc_en_q;
  logic           done_q;

  // Ready depends only on the registered count, never on a same-cycle pop.
  assign fifo_empty = (fifo_count == '0);
  assign in_ready   = (fifo_count < CW'(DEPTH));
  assign push       = in_valid && in_ready;
  assign pop_last   = fifo_rd[N*DATA_WIDTH];

  sync_fifo #(
    .WIDTH(N * DATA_WIDTH + 1),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rstn),
    .push_i   (push),
    .wr_data_i({in_last, in_data}),
    .pop_i    (pop),
    .rd_data_o(fifo_rd),
    .count_o  (fifo_count)
  );

  // NOTE: every signal written here gets a default first, so no path leaves
  // one unassigned and no latch is inferred.
  always_comb begin
    state_d     = state_q;
    flush_cnt_d = flush_cnt_q;
    done_pend_d = 1'b0;
    adv         = 1'b0;
    pop         = 1'b0;
    case (state_q)
      IDLE, STREAM: begin
        if (!fifo_empty) begin
          adv = 1'b1;
          pop = 1'b1;
          if (!pop_last) begin
            state_d = STREAM;
          end else if (N == 1) begin
            state_d     = IDLE;
            done_pend_d = 1'b1;
          end else begin
            state_d = FLUSH;
          end
        end
      end
      FLUSH: begin
        adv = 1'b1;
        if (flush_cnt_q == FLUSH_LAST) begin
          state_d     = IDLE;
          flush_cnt_d = '0;
          done_pend_d = 1'b1;
        end else begin
          flush_cnt_d = flush_cnt_q + FCW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // done is delayed one extra cycle so it lands after acc_en has dropped.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= IDLE;
      flush_cnt_q <= '0;
      done_pend_q <= 1'b0;
      done_q      <= 1'b0;
      acc_en_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      flush_cnt_q <= flush_cnt_d;
      done_pend_q <= done_pend_d;
      done_q      <= done_pend_q;
      acc_en_q    <= adv;
    end
  end

  for (genvar k = 0; k < N; k++) begin : g_lane
    logic [DATA_WIDTH-1:0] head;
    logic [DATA_WIDTH-1:0] sr_q [k+1];

    assign head = (state_q == FLUSH) ? '0 : fifo_rd[k*DATA_WIDTH +: DATA_WIDTH];

    // Lane k is k+1 stages deep; all lanes move together so skew survives stalls.
    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
        for (int i = 0; i <= k; i++) begin
          sr_q[i] <= '0;
        end
      end else if (adv) begin
        sr_q[0] <= head;
        for (int i = 1; i <= k; i++) begin
          sr_q[i] <= sr_q[i-1];
        end
      end
    end

    assign data_o[k*DATA_WIDTH +: DATA_WIDTH] = sr_q[k];
  end

  assign acc_en_o = acc_en_q;
  assign busy_o   = (state_q != IDLE);
  assign done_o   = done_q;

endmodule
